irq_trap_sequencer: RTL and testbench

- Sequences machine-mode interrupt entry, WFI sleep and MRET return for the 5-stage core.
- Sits beside ID_state and drives its interrupt_stall and flush inputs.
- Writes mepc/mcause into the CSR file and redirects the IF program counter.
- Waits for in-flight EXE/MEM/WB work and any data-memory stall to drain before a trap is taken.

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_sync.sv | 25 ++
 rtl/irq_trap_sequencer.sv | 175 +++++++++++++++++
 tb/tb_irq_trap_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt/trap sequencer.
package irq_pkg;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    TRAP,
    SLEEP,
    RET
  } irq_state_e;

  localparam logic [31:0] CAUSE_MEI = 32'h8000000B;
  localparam logic [31:0] CAUSE_MTI = 32'h80000007;

  // External interrupt has priority over timer when both are pending.
  function automatic logic [31:0] irq_cause(input logic ext_pending);
    return ext_pending ? CAUSE_MEI : CAUSE_MTI;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for one interrupt level input.
// With Bypass set the raw input is forwarded and the flops are left dangling for synthesis to prune.
module irq_sync #(
  parameter bit Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the level through two flops to resolve metastability.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = Bypass ? d_i : sync_q[1];

endmodule

// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt entry, WFI sleep and MRET return sequencer for the 5-stage core.
// Optional feature: define IRQ_SYNC_EN to pass ext_irq/timer_irq through 2-flop synchronizers.
module irq_trap_sequencer
  import irq_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] pc_ID,
  input  logic        isWFI_ID,
  input  logic        isMRET_ID,
  input  logic        DM_stall,
  output logic        interrupt_stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        mepc_we,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mcause_wdata,
  output logic        mip_meip,
  output logic        mip_mtip,
  output logic        trap_taken
);

`ifdef IRQ_SYNC_EN
  localparam bit SyncBypass = 1'b0;
`else
  localparam bit SyncBypass = 1'b1;
`endif

  localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(DRAIN_CYCLES);

  logic ext_s, tim_s;

  irq_sync #(.Bypass(SyncBypass)) u_sync_ext (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (ext_irq),
    .q_o   (ext_s)
  );

  irq_sync #(.Bypass(SyncBypass)) u_sync_tim (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (timer_irq),
    .q_o   (tim_s)
  );

  logic ext_pend, pending, take;
  assign ext_pend = ext_s & mie_meie;
  assign pending  = ext_pend | (tim_s & mie_mtie);
  assign take     = pending & mstatus_mie;

  irq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_dec;
  logic [31:0]      epc_q, cause_q, pc_next_id;
  logic             meip_q, mtip_q;

  // The decrement and the exit test share one cycle, so DRAIN lasts exactly DRAIN_CYCLES cycles.
  assign cnt_dec    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
  assign pc_next_id = pc_ID + 32'd4;

  // Sequencer state, drain counter, captured trap context and mip pending bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      meip_q  <= 1'b0;
      mtip_q  <= 1'b0;
    end else begin
      meip_q <= ext_s;
      mtip_q <= tim_s;
      case (state_q)
        RUN: begin
          if (take && !DM_stall) begin
            epc_q   <= pc_ID;
            cause_q <= irq_cause(ext_pend);
            cnt_q   <= DrainLoad;
            state_q <= DRAIN;
          end else if (isMRET_ID) begin
            state_q <= RET;
          end else if (isWFI_ID && !pending) begin
            state_q <= SLEEP;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_dec;
          if (cnt_dec == '0 && !DM_stall) begin
            state_q <= TRAP;
          end
        end
        TRAP: state_q <= RUN;
        SLEEP: begin
          if (pending) begin
            if (mstatus_mie) begin
              epc_q   <= pc_next_id;
              cause_q <= irq_cause(ext_pend);
              cnt_q   <= DrainLoad;
              state_q <= DRAIN;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RET: begin
          if (!DM_stall) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Control strobes decoded from state; reset forces them low immediately.
  always_comb begin
    interrupt_stall = 1'b0;
    flush           = 1'b0;
    pc_redirect     = 1'b0;
    pc_target       = '0;
    mepc_we         = 1'b0;
    mepc_wdata      = '0;
    mcause_wdata    = '0;
    trap_taken      = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          flush = (take & ~DM_stall) | isMRET_ID | (isWFI_ID & ~pending);
        end
        DRAIN: interrupt_stall = 1'b1;
        TRAP: begin
          interrupt_stall = 1'b1;
          flush           = 1'b1;
          pc_redirect     = 1'b1;
          pc_target       = {mtvec[31:2], 2'b00};
          mepc_we         = 1'b1;
          mepc_wdata      = epc_q;
          mcause_wdata    = cause_q;
          trap_taken      = 1'b1;
        end
        SLEEP: begin
          interrupt_stall = 1'b1;
          if (pending && !mstatus_mie) begin
            pc_redirect = 1'b1;
            pc_target   = pc_next_id;
          end
        end
        RET: begin
          interrupt_stall = DM_stall;
          if (!DM_stall) begin
            pc_redirect = 1'b1;
            pc_target   = mepc;
            flush       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mip_meip = meip_q;
  assign mip_mtip = mtip_q;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Directed, table-driven bench for irq_trap_sequencer (default build, raw interrupt inputs).
module tb_irq_trap_sequencer;

  typedef struct packed {
    logic        ext, tim, mie, meie, mtie, wfi, mret, dm;
    logic [31:0] pc;
    logic [31:0] mtvec;
  } in_t;

  typedef struct packed {
    logic        st, fl, rd;
    logic [31:0] tgt;
    logic        we;
    logic [31:0] wd;
    logic [31:0] cs;
    logic        tr;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, timer_irq, mstatus_mie, mie_meie, mie_mtie;
  logic [31:0] mtvec, mepc, pc_ID;
  logic        isWFI_ID, isMRET_ID, DM_stall;
  logic        interrupt_stall, flush, pc_redirect, mepc_we, mip_meip, mip_mtip, trap_taken;
  logic [31:0] pc_target, mepc_wdata, mcause_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  irq_trap_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .ext_irq         (ext_irq),
    .timer_irq       (timer_irq),
    .mstatus_mie     (mstatus_mie),
    .mie_meie        (mie_meie),
    .mie_mtie        (mie_mtie),
    .mtvec           (mtvec),
    .mepc            (mepc),
    .pc_ID           (pc_ID),
    .isWFI_ID        (isWFI_ID),
    .isMRET_ID       (isMRET_ID),
    .DM_stall        (DM_stall),
    .interrupt_stall (interrupt_stall),
    .flush           (flush),
    .pc_redirect     (pc_redirect),
    .pc_target       (pc_target),
    .mepc_we         (mepc_we),
    .mepc_wdata      (mepc_wdata),
    .mcause_wdata    (mcause_wdata),
    .mip_meip        (mip_meip),
    .mip_mtip        (mip_mtip),
    .trap_taken      (trap_taken)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(bit ext, bit tim, bit mie, bit meie, bit mtie, bit wfi, bit mret,
                                bit dm, logic [31:0] pc, logic [31:0] tv);
    in_t v;
    v.ext = ext; v.tim = tim; v.mie = mie; v.meie = meie; v.mtie = mtie;
    v.wfi = wfi; v.mret = mret; v.dm = dm; v.pc = pc; v.mtvec = tv;
    return v;
  endfunction

  function automatic out_t mk_out(bit st, bit fl, bit rd, logic [31:0] tgt, bit we,
                                  logic [31:0] wd, logic [31:0] cs, bit tr);
    out_t o;
    o.st = st; o.fl = fl; o.rd = rd; o.tgt = tgt; o.we = we; o.wd = wd; o.cs = cs; o.tr = tr;
    return o;
  endfunction

  function automatic out_t o_trap(logic [31:0] tgt, logic [31:0] wd, logic [31:0] cs);
    return mk_out(1, 1, 1, tgt, 1, wd, cs, 1);
  endfunction

  task automatic apply(input in_t v);
    ext_irq = v.ext; timer_irq = v.tim; mstatus_mie = v.mie; mie_meie = v.meie;
    mie_mtie = v.mtie; isWFI_ID = v.wfi; isMRET_ID = v.mret; DM_stall = v.dm;
    pc_ID = v.pc; mtvec = v.mtvec;
  endtask

  // mcause_wdata is only meaningful while mepc_we is high.
  task automatic check(input string name, input out_t exp);
    out_t got;
    bit   ok;
    got = {interrupt_stall, flush, pc_redirect, pc_target, mepc_we, mepc_wdata, mcause_wdata,
           trap_taken};
    ok = (got.st == exp.st) && (got.fl == exp.fl) && (got.rd == exp.rd) && (got.tgt == exp.tgt) &&
         (got.we == exp.we) && (got.wd == exp.wd) && (got.tr == exp.tr) &&
         (!exp.we || (got.cs == exp.cs));
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got stall=%0b flush=%0b redir=%0b tgt=%h we=%0b wd=%h cause=%h trap=%0b; required stall=%0b flush=%0b redir=%0b tgt=%h we=%0b wd=%h cause=%h trap=%0b",
                  name, got.st, got.fl, got.rd, got.tgt, got.we, got.wd, got.cs, got.tr,
                  exp.st, exp.fl, exp.rd, exp.tgt, exp.we, exp.wd, exp.cs, exp.tr);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b required %0b", name, got, exp);
  endtask

  // One cycle: drive at negedge, compare 1 time unit later, well before the next posedge.
  task automatic cycle(input string name, input in_t v, input out_t exp);
    @(negedge clk);
    apply(v);
    #1;
    check(name, exp);
  endtask

  vec_t vecs[$];

  initial begin
    out_t O0, OF, OS;
    logic [31:0] TV;
    logic [31:0] MEI, MTI;
    O0  = mk_out(0, 0, 0, 0, 0, 0, 0, 0);
    OF  = mk_out(0, 1, 0, 0, 0, 0, 0, 0);
    OS  = mk_out(1, 0, 0, 0, 0, 0, 0, 0);
    TV  = 32'h200;
    MEI = 32'h8000000B;
    MTI = 32'h80000007;

    // External irq entry: flush, 3 drain cycles, trap.
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0,32'h100,TV), O0});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h100,TV), OF});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h104,TV), OS});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h104,TV), OS});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h104,TV), OS});
    vecs.push_back('{mk_in(0,0,0,1,0,0,0,0,32'h104,TV), o_trap(32'h200, 32'h100, MEI)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0,32'h200,TV), O0});
    // Both sources at once: external wins; unaligned mtvec low bits are cleared.
    vecs.push_back('{mk_in(1,1,1,1,1,0,0,0,32'h300,TV), OF});
    vecs.push_back('{mk_in(1,1,1,1,1,0,0,0,32'h304,TV), OS});
    vecs.push_back('{mk_in(1,1,1,1,1,0,0,0,32'h304,TV), OS});
    vecs.push_back('{mk_in(1,1,1,1,1,0,0,0,32'h304,TV), OS});
    vecs.push_back('{mk_in(0,0,0,1,1,0,0,0,32'h304,32'h207), o_trap(32'h204, 32'h300, MEI)});
    // Timer only.
    vecs.push_back('{mk_in(0,1,1,1,1,0,0,0,32'h400,TV), OF});
    vecs.push_back('{mk_in(0,1,1,1,1,0,0,0,32'h404,TV), OS});
    vecs.push_back('{mk_in(0,1,1,1,1,0,0,0,32'h404,TV), OS});
    vecs.push_back('{mk_in(0,1,1,1,1,0,0,0,32'h404,TV), OS});
    vecs.push_back('{mk_in(0,0,0,1,1,0,0,0,32'h404,TV), o_trap(32'h200, 32'h400, MTI)});
    // take blocked by DM_stall: no capture until stall drops.
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,1,32'h500,TV), O0});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,1,32'h504,TV), O0});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h508,TV), OF});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h50C,TV), OS});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h50C,TV), OS});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h50C,TV), OS});
    vecs.push_back('{mk_in(0,0,0,1,0,0,0,0,32'h50C,TV), o_trap(32'h200, 32'h508, MEI)});
    // take together with MRET: interrupt wins, epc is the MRET's PC.
    vecs.push_back('{mk_in(1,0,1,1,0,0,1,0,32'h600,TV), OF});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h604,TV), OS});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h604,TV), OS});
    vecs.push_back('{mk_in(1,0,1,1,0,0,0,0,32'h604,TV), OS});
    vecs.push_back('{mk_in(0,0,0,1,0,0,0,0,32'h604,TV), o_trap(32'h200, 32'h600, MEI)});
    // WFI with a pending (but globally masked) irq does not sleep.
    vecs.push_back('{mk_in(0,1,0,0,1,1,0,0,32'h700,TV), O0});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0,32'h704,TV), O0});

    mepc = 32'h0;
    apply(mk_in(1,1,1,1,1,0,0,0,32'h100,TV));
    rst = 1'b1;
    #1;
    check("reset_outputs", O0);
    check_bit("reset_mip_meip", mip_meip, 1'b0);
    check_bit("reset_mip_mtip", mip_mtip, 1'b0);
    @(negedge clk);
    apply(mk_in(0,0,0,0,0,0,0,0,32'h100,TV));
    rst = 1'b0;

    foreach (vecs[k]) begin
      cycle($sformatf("vec%0d", k), vecs[k].i, vecs[k].o);
    end

    // DM_stall high for 5 cycles once the drain counter is exhausted.
    cycle("dm_take", mk_in(1,0,1,1,0,0,0,0,32'h800,TV), OF);
    cycle("dm_drain1", mk_in(1,0,1,1,0,0,0,0,32'h804,TV), OS);
    cycle("dm_drain2", mk_in(1,0,1,1,0,0,0,0,32'h804,TV), OS);
    for (int c = 0; c < 5; c++) begin
      cycle($sformatf("dm_hold%0d", c), mk_in(0,0,0,1,0,0,0,1,32'h804,TV), OS);
    end
    cycle("dm_release", mk_in(0,0,0,1,0,0,0,0,32'h804,TV), OS);
    cycle("dm_trap", mk_in(0,0,0,1,0,0,0,0,32'h804,TV), o_trap(32'h200, 32'h800, MEI));
    cycle("dm_idle", mk_in(0,0,0,0,0,0,0,0,32'h200,TV), O0);

    // WFI at the top of memory, woken by a masked timer irq: resume at wrapped PC+4.
    cycle("wfi_enter", mk_in(0,0,0,0,1,1,0,0,32'hFFFFFFFC,TV), OF);
    cycle("wfi_sleep1", mk_in(0,0,0,0,1,0,0,0,32'hFFFFFFFC,TV), OS);
    cycle("wfi_sleep2", mk_in(0,0,0,0,1,0,0,0,32'hFFFFFFFC,TV), OS);
    cycle("wfi_wake", mk_in(0,1,0,0,1,0,0,0,32'hFFFFFFFC,TV), mk_out(1,0,1,32'h0,0,0,0,0));
    cycle("wfi_run", mk_in(0,1,0,0,1,0,0,0,32'h0,TV), O0);
    check_bit("mip_mtip_set", mip_mtip, 1'b1);
    check_bit("mip_meip_clr", mip_meip, 1'b0);

    // WFI woken by an enabled irq: trap with epc = WFI PC + 4.
    cycle("wfi2_enter", mk_in(0,0,1,0,1,1,0,0,32'h900,TV), OF);
    cycle("wfi2_sleep", mk_in(0,0,1,0,1,0,0,0,32'h900,TV), OS);
    cycle("wfi2_wake", mk_in(0,1,1,0,1,0,0,0,32'h900,TV), OS);
    cycle("wfi2_drain1", mk_in(0,1,1,0,1,0,0,0,32'h900,TV), OS);
    cycle("wfi2_drain2", mk_in(0,1,1,0,1,0,0,0,32'h900,TV), OS);
    cycle("wfi2_drain3", mk_in(0,1,1,0,1,0,0,0,32'h900,TV), OS);
    cycle("wfi2_trap", mk_in(0,0,0,0,1,0,0,0,32'h900,TV), o_trap(32'h200, 32'h904, MTI));

    // MRET held off by DM_stall for 2 cycles.
    mepc = 32'h1234;
    cycle("mret_id", mk_in(0,0,0,0,0,0,1,0,32'hA00,TV), OF);
    cycle("mret_stall1", mk_in(0,0,0,0,0,0,0,1,32'hA00,TV), OS);
    cycle("mret_stall2", mk_in(0,0,0,0,0,0,0,1,32'hA00,TV), OS);
    cycle("mret_go", mk_in(0,0,0,0,0,0,0,0,32'hA00,TV), mk_out(0,1,1,32'h1234,0,0,0,0));
    cycle("mret_run", mk_in(0,0,0,0,0,0,0,0,32'h1234,TV), O0);
    check_bit("mip_meip_low", mip_meip, 1'b0);

    // Reset mid-drain: outputs drop at once, no trap afterwards.
    cycle("rst_take", mk_in(1,0,1,1,0,0,0,0,32'hB00,TV), OF);
    cycle("rst_drain", mk_in(1,0,1,1,0,0,0,0,32'hB04,TV), OS);
    check_bit("mip_meip_set", mip_meip, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", O0);
    check_bit("rst_mip_meip", mip_meip, 1'b0);
    @(negedge clk);
    apply(mk_in(0,0,0,0,0,0,0,0,32'hB04,TV));
    rst = 1'b0;
    #1;
    check("rst_release", O0);
    for (int c = 0; c < 5; c++) begin
      cycle($sformatf("rst_after%0d", c), mk_in(0,0,0,0,0,0,0,0,32'hB04,TV), O0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
